// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide execution stage.
// Accepts one request per WIDTH+1 cycles and returns a single result through the
// register-file write triple (WriteRegister/WriteData/RegWrite).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request strobe, honoured in IDLE or DONE only
//   op              00 MUL low, 01 MUL high, 10 DIV quotient, 11 DIV remainder
//   OperandA        multiplicand / dividend
//   OperandB        multiplier / divisor
//   DestReg         destination register number
//   busy            high while the operation is iterating
//   done            one-cycle result-valid pulse
//   div_zero        divide-by-zero flag, valid with done, held with WriteData
//   WriteData       result, held until the next completion
//   WriteRegister   destination register of the held result
//   RegWrite        write strobe, identical to done
module mul_div_unit #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [WIDTH-1:0]      OperandA,
  input  logic [WIDTH-1:0]      OperandB,
  input  logic [REG_ADDR_W-1:0] DestReg,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic [WIDTH-1:0]      WriteData,
  output logic [REG_ADDR_W-1:0] WriteRegister,
  output logic                  RegWrite
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [1:0]              op_q, op_d;
  logic [REG_ADDR_W-1:0]   dest_q, dest_d;
  // MUL: acc = {product high, multiplier/product low}; DIV: acc = {remainder, quotient}.
  logic [2*WIDTH-1:0]      acc_q, acc_d;
  // MUL: multiplicand; DIV: divisor.
  logic [WIDTH-1:0]        opnd_q, opnd_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;
  logic [REG_ADDR_W-1:0]   wreg_q, wreg_d;
  logic                    dz_q, dz_d;

  logic [WIDTH:0]          mul_sum;
  logic [WIDTH:0]          trial;
  logic [WIDTH:0]          diff;
  logic                    ge;
  logic [2*WIDTH-1:0]      step_acc;

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    trial   = acc_q[2*WIDTH-1:WIDTH-1];
    diff    = trial - {1'b0, opnd_q};
    ge      = (trial >= {1'b0, opnd_q});
    if (op_q[1]) begin
      // A zero divisor always "fits": quotient fills with ones, remainder ends as dividend.
      step_acc = {(ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
    end else begin
      step_acc = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    dest_d  = dest_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    wdata_d = wdata_q;
    wreg_d  = wreg_q;
    dz_d    = dz_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StCalc;
          count_d = '0;
          op_d    = op;
          dest_d  = DestReg;
          if (op[1]) begin
            opnd_d = OperandB;
            acc_d  = {{WIDTH{1'b0}}, OperandA};
          end else begin
            opnd_d = OperandA;
            acc_d  = {{WIDTH{1'b0}}, OperandB};
          end
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        acc_d   = step_acc;
        count_d = count_q + CntW'(1);
        if (count_q == LastCnt) begin
          state_d = StDone;
          wdata_d = op_q[0] ? step_acc[2*WIDTH-1:WIDTH] : step_acc[WIDTH-1:0];
          wreg_d  = dest_q;
          dz_d    = op_q[1] && (opnd_q == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      wdata_q <= '0;
      wreg_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      wdata_q <= wdata_d;
      wreg_q  <= wreg_d;
      dz_q    <= dz_d;
    end
  end

  assign busy          = (state_q == StCalc);
  assign done          = (state_q == StDone);
  assign RegWrite      = done;
  assign div_zero      = dz_q;
  assign WriteData     = wdata_q;
  assign WriteRegister = wreg_q;

endmodule
